// File: rtl/audio_mix_serializer.sv
// N-channel gain/route mixer with sequential MAC, saturation and a codec DACDAT serialiser.
// Optional peak meters: define AUDIO_MIX_PEAK_EN to add the peak_l / peak_r outputs.
module audio_mix_serializer #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W   = 8,
  parameter int I2S_MODE = 0
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset,
  input  logic                         aud_bclk,
  input  logic                         aud_daclrc,
  output logic                         aud_dacdat,
  input  logic [NUM_CH*SAMPLE_W-1:0]   ch_samples,
  input  logic [NUM_CH*GAIN_W-1:0]     ch_gain,
  input  logic [NUM_CH-1:0]            ch_route,
  input  logic                         mute,
  input  logic                         clr_status,
  output logic                         clip_l,
  output logic                         clip_r,
  output logic                         overrun,
`ifdef AUDIO_MIX_PEAK_EN
  output logic [SAMPLE_W-2:0]          peak_l,
  output logic [SAMPLE_W-2:0]          peak_r,
`endif
  output logic [1:0]                   fsm_state
);

  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
  localparam int ACC_W  = PROD_W + $clog2(NUM_CH);
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W  = $clog2(SAMPLE_W + 1);
  localparam int FRAC   = 7;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, SAT = 2'd2} state_t;

  state_t                      state;
  logic [IDX_W-1:0]            idx;
  logic signed [ACC_W-1:0]     acc_l, acc_r;
  logic signed [SAMPLE_W-1:0]  samp_sh [NUM_CH];
  logic [GAIN_W-1:0]           gain_sh [NUM_CH];
  logic [NUM_CH-1:0]           route_sh;
  logic                        mute_sh;
  logic [SAMPLE_W-1:0]         mix_l, mix_r;

  // [0],[1] synchroniser flops, [2] history for edge detection
  logic [2:0] bclk_sr, lrc_sr;
  logic       bclk_fall, lrc_rise, lrc_fall, left_start, right_start;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      bclk_sr <= '0;
      lrc_sr  <= '0;
    end else begin
      bclk_sr <= {bclk_sr[1:0], aud_bclk};
      lrc_sr  <= {lrc_sr[1:0], aud_daclrc};
    end
  end

  assign bclk_fall   = bclk_sr[2] & ~bclk_sr[1];
  assign lrc_rise    = ~lrc_sr[2] & lrc_sr[1];
  assign lrc_fall    = lrc_sr[2] & ~lrc_sr[1];
  assign left_start  = (I2S_MODE == 0) ? lrc_rise : lrc_fall;
  assign right_start = (I2S_MODE == 0) ? lrc_fall : lrc_rise;

  function automatic logic [SAMPLE_W:0] saturate(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> FRAC;
    if (sh > SAT_MAX)      saturate = {1'b1, 1'b0, {(SAMPLE_W-1){1'b1}}};
    else if (sh < SAT_MIN) saturate = {1'b1, 1'b1, {(SAMPLE_W-1){1'b0}}};
    else                   saturate = {1'b0, sh[SAMPLE_W-1:0]};
  endfunction

  logic signed [PROD_W-1:0] samp_ext, gain_ext, prod;
  logic [SAMPLE_W:0]        sat_l, sat_r;
  logic [SAMPLE_W-1:0]      new_l, new_r;
  logic                     clip_l_ev, clip_r_ev, overrun_ev;

  always_comb begin
    samp_ext   = PROD_W'(samp_sh[idx]);
    gain_ext   = PROD_W'($signed({1'b0, gain_sh[idx]}));
    prod       = samp_ext * gain_ext;
    sat_l      = saturate(acc_l);
    sat_r      = saturate(acc_r);
    new_l      = mute_sh ? '0 : sat_l[SAMPLE_W-1:0];
    new_r      = mute_sh ? '0 : sat_r[SAMPLE_W-1:0];
    clip_l_ev  = (state == SAT) && !mute_sh && sat_l[SAMPLE_W];
    clip_r_ev  = (state == SAT) && !mute_sh && sat_r[SAMPLE_W];
    overrun_ev = left_start && (state != IDLE);
  end

`ifdef AUDIO_MIX_PEAK_EN
  // Magnitude with the most negative code folded onto the largest positive one.
  function automatic logic [SAMPLE_W-2:0] mag(input logic [SAMPLE_W-1:0] v);
    logic [SAMPLE_W-1:0] n;
    n = -v;
    if (!v[SAMPLE_W-1])              mag = v[SAMPLE_W-2:0];
    else if (v[SAMPLE_W-2:0] == '0)  mag = '1;
    else                             mag = n[SAMPLE_W-2:0];
  endfunction

  logic [SAMPLE_W-2:0] mag_l, mag_r;
  assign mag_l = mag(new_l);
  assign mag_r = mag(new_r);
`endif

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state    <= IDLE;
      idx      <= '0;
      acc_l    <= '0;
      acc_r    <= '0;
      route_sh <= '0;
      mute_sh  <= 1'b0;
      mix_l    <= '0;
      mix_r    <= '0;
      clip_l   <= 1'b0;
      clip_r   <= 1'b0;
      overrun  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        samp_sh[i] <= '0;
        gain_sh[i] <= '0;
      end
`ifdef AUDIO_MIX_PEAK_EN
      peak_l <= '0;
      peak_r <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (left_start) begin
            for (int i = 0; i < NUM_CH; i++) begin
              samp_sh[i] <= ch_samples[i*SAMPLE_W +: SAMPLE_W];
              gain_sh[i] <= ch_gain[i*GAIN_W +: GAIN_W];
            end
            route_sh <= ch_route;
            mute_sh  <= mute;
            acc_l    <= '0;
            acc_r    <= '0;
            idx      <= '0;
            state    <= MAC;
          end
        end
        MAC: begin
          if (route_sh[idx]) acc_r <= acc_r + ACC_W'(prod);
          else               acc_l <= acc_l + ACC_W'(prod);
          if (idx == IDX_W'(NUM_CH - 1)) state <= SAT;
          else                           idx   <= idx + 1'b1;
        end
        SAT: begin
          mix_l <= new_l;
          mix_r <= new_r;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Set events take priority over a simultaneous clear.
      if (clip_l_ev)       clip_l <= 1'b1;
      else if (clr_status) clip_l <= 1'b0;
      if (clip_r_ev)       clip_r <= 1'b1;
      else if (clr_status) clip_r <= 1'b0;
      if (overrun_ev)      overrun <= 1'b1;
      else if (clr_status) overrun <= 1'b0;

`ifdef AUDIO_MIX_PEAK_EN
      if (state == SAT) begin
        peak_l <= (clr_status || mag_l > peak_l) ? mag_l : peak_l;
        peak_r <= (clr_status || mag_r > peak_r) ? mag_r : peak_r;
      end else if (clr_status) begin
        peak_l <= '0;
        peak_r <= '0;
      end
`endif
    end
  end

  assign fsm_state = state;

  // Serialiser. mix_r is snapshotted at left_start so both words sent in a
  // frame come from the previous frame's computation.
  logic [SAMPLE_W-1:0] shreg, hold_r;
  logic [CNT_W-1:0]    bitcnt;
  logic                wait_first;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      shreg      <= '0;
      hold_r     <= '0;
      bitcnt     <= '0;
      wait_first <= 1'b0;
    end else if (left_start) begin
      shreg      <= mix_l;
      hold_r     <= mix_r;
      bitcnt     <= CNT_W'(SAMPLE_W);
      wait_first <= (I2S_MODE != 0);
    end else if (right_start) begin
      shreg      <= hold_r;
      bitcnt     <= CNT_W'(SAMPLE_W);
      wait_first <= (I2S_MODE != 0);
    end else if (bclk_fall) begin
      if (wait_first) begin
        wait_first <= 1'b0;
      end else if (bitcnt != '0) begin
        shreg  <= shreg << 1;
        bitcnt <= bitcnt - 1'b1;
      end
    end
  end

  assign aud_dacdat = (bitcnt != '0) && !wait_first && shreg[SAMPLE_W-1];

endmodule

// File: tb/tb_audio_mix_serializer.sv
// Bench: a left-justified and an I2S instance share stimulus; words are captured as a codec would on BCLK rise.
module tb_audio_mix_serializer;
  localparam int NUM_CH   = 4;
  localparam int SAMPLE_W = 16;
  localparam int GAIN_W   = 8;

  // clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic bclk = 1'b1;
  logic lrc  = 1'b0;
  logic lrc_n;
  assign lrc_n = ~lrc;

  logic [NUM_CH*SAMPLE_W-1:0] samples = '0;
  logic [NUM_CH*GAIN_W-1:0]   gains   = '0;
  logic [NUM_CH-1:0]          routes  = '0;
  logic                       mute    = 1'b0;
  logic                       clr     = 1'b0;

  logic dac0, cl0, cr0, ov0, dac1, cl1, cr1, ov1;
  logic [1:0] st0, st1;

  audio_mix_serializer #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .GAIN_W(GAIN_W), .I2S_MODE(0)) dut (
    .clk_clk(clk), .reset_reset(rst), .aud_bclk(bclk), .aud_daclrc(lrc), .aud_dacdat(dac0),
    .ch_samples(samples), .ch_gain(gains), .ch_route(routes), .mute(mute), .clr_status(clr),
    .clip_l(cl0), .clip_r(cr0), .overrun(ov0), .fsm_state(st0));

  audio_mix_serializer #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .GAIN_W(GAIN_W), .I2S_MODE(1)) dut_i2s (
    .clk_clk(clk), .reset_reset(rst), .aud_bclk(bclk), .aud_daclrc(lrc_n), .aud_dacdat(dac1),
    .ch_samples(samples), .ch_gain(gains), .ch_route(routes), .mute(mute), .clr_status(clr),
    .clip_l(cl1), .clip_r(cr1), .overrun(ov1), .fsm_state(st1));

  int total = 0;
  int bad   = 0;
  logic [SAMPLE_W-1:0] exp_q[$];
  bit m_clip_l, m_clip_r, m_ovr;
  logic [17:0] rx0, rx1;

  // Length of each busy (non-idle) stretch of the left-justified instance
  int busy_cnt = 0, busy_len = 0, busy_runs = 0;
  always @(negedge clk) begin
    if (rst) busy_cnt = 0;
    else if (st0 != 2'd0) busy_cnt++;
    else if (busy_cnt != 0) begin
      busy_len = busy_cnt;
      busy_runs++;
      busy_cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: integer sums, floor division by 128, clamp to 16-bit signed.
  function automatic longint floor_div128(input longint x);
    if (x >= 0) return x / 128;
    return -((-x + 127) / 128);
  endfunction

  task automatic clamp(input longint x, output logic [SAMPLE_W-1:0] w, output bit c);
    c = 1'b0;
    if (x > 32767) begin x = 32767; c = 1'b1; end
    if (x < -32768) begin x = -32768; c = 1'b1; end
    w = 16'(x);
  endtask

  task automatic model_frame(output logic [SAMPLE_W-1:0] ml, output logic [SAMPLE_W-1:0] mr);
    longint sum_l = 0, sum_r = 0, v;
    bit cl, cr;
    for (int i = 0; i < NUM_CH; i++) begin
      v = longint'($signed(samples[i*SAMPLE_W +: SAMPLE_W])) * longint'(gains[i*GAIN_W +: GAIN_W]);
      if (routes[i]) sum_r += v;
      else           sum_l += v;
    end
    clamp(floor_div128(sum_l), ml, cl);
    clamp(floor_div128(sum_r), mr, cr);
    if (mute) begin
      ml = '0;
      mr = '0;
    end else begin
      m_clip_l |= cl;
      m_clip_r |= cr;
    end
  endtask

  // drivers
  task automatic clear_inputs();
    samples = '0;
    gains   = '0;
    routes  = '0;
    mute    = 1'b0;
  endtask

  task automatic set_ch(input int i, input logic [15:0] s, input logic [7:0] g, input logic r);
    samples[i*SAMPLE_W +: SAMPLE_W] = s;
    gains[i*GAIN_W +: GAIN_W]       = g;
    routes[i]                       = r;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NUM_CH; i++)
      set_ch(i, 16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    mute = 1'b0;
  endtask

  // One LRC half: 18 BCLK periods, LRC toggles with the first falling edge,
  // DACDAT sampled at each rising edge.
  task automatic do_half(input logic lv);
    for (int i = 0; i < 18; i++) begin
      bclk = 1'b0;
      if (i == 0) lrc = lv;
      repeat (8) @(negedge clk);
      bclk = 1'b1;
      rx0[i] = dac0;
      rx1[i] = dac1;
      repeat (8) @(negedge clk);
    end
  endtask

  function automatic logic [15:0] word_from(input logic [17:0] rx, input int first);
    logic [15:0] w;
    for (int k = 0; k < 16; k++) w[15-k] = rx[first+k];
    return w;
  endfunction

  task automatic check_half(input string tag, input logic [15:0] exp);
    chk({tag, "_lj_word"},  32'(word_from(rx0, 0)), 32'(exp));
    chk({tag, "_lj_tail"},  32'({rx0[16], rx0[17]}), 32'd0);
    chk({tag, "_i2s_lead"}, 32'(rx1[0]), 32'd0);
    chk({tag, "_i2s_word"}, 32'(word_from(rx1, 1)), 32'(exp));
    chk({tag, "_i2s_tail"}, 32'(rx1[17]), 32'd0);
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_flags"},     32'({cl0, cr0, ov0}), 32'({m_clip_l, m_clip_r, m_ovr}));
    chk({tag, "_flags_i2s"}, 32'({cl1, cr1, ov1}), 32'({m_clip_l, m_clip_r, m_ovr}));
  endtask

  // scoreboard: each frame sends the previous frame's pair and queues its own
  task automatic frame(input string tag);
    logic [15:0] el, er, nl, nr;
    int runs0;
    el = exp_q.pop_front();
    er = exp_q.pop_front();
    model_frame(nl, nr);
    exp_q.push_back(nl);
    exp_q.push_back(nr);
    runs0 = busy_runs;
    do_half(1'b1);
    check_half({tag, "_left"}, el);
    do_half(1'b0);
    check_half({tag, "_right"}, er);
    chk({tag, "_busy_cycles"}, 32'(busy_len), 32'(NUM_CH + 1));
    chk({tag, "_busy_runs"}, 32'(busy_runs - runs0), 32'd1);
    check_flags(tag);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_clip_l = 1'b0;
    m_clip_r = 1'b0;
    m_ovr    = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] nl, nr;
    int runs0;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    repeat (4) @(negedge clk);
    chk("reset_dacdat", 32'({dac0, dac1}), 32'd0);
    check_flags("reset");
    chk("reset_state", 32'({st0, st1}), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_state", 32'(st0), 32'd0);

    clear_inputs();
    set_ch(0, 16'h1234, 8'd128, 1'b0);
    frame("unity_in");

    clear_inputs();
    set_ch(1, 16'h4000, 8'd64, 1'b1);
    set_ch(2, 16'h2000, 8'd128, 1'b1);
    frame("gain_route_in");

    clear_inputs();
    set_ch(0, 16'h7000, 8'd128, 1'b0);
    set_ch(1, 16'h7000, 8'd128, 1'b0);
    frame("sat_pos_in");

    clear_inputs();
    set_ch(0, 16'h9000, 8'd128, 1'b0);
    set_ch(1, 16'h9000, 8'd128, 1'b0);
    frame("sat_neg_in");

    pulse_clr();
    check_flags("clr_after_sat");

    for (int i = 0; i < NUM_CH; i++) set_ch(i, 16'h7FFF, 8'd255, 1'(i % 2));
    mute = 1'b1;
    frame("mute_in");

    for (int n = 0; n < 6; n++) begin
      rand_inputs();
      frame("random_in");
    end

    // Second left edge lands while the MAC is still running.
    rand_inputs();
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    model_frame(nl, nr);
    exp_q.push_back(nl);
    exp_q.push_back(nr);
    runs0 = busy_runs;
    lrc = 1'b1;
    repeat (2) @(negedge clk);
    lrc = 1'b0;
    repeat (2) @(negedge clk);
    lrc = 1'b1;
    repeat (20) @(negedge clk);
    m_ovr = 1'b1;
    check_flags("overrun");
    chk("overrun_busy_cycles", 32'(busy_len), 32'(NUM_CH + 1));
    chk("overrun_busy_runs", 32'(busy_runs - runs0), 32'd1);
    do_half(1'b0);
    rand_inputs();
    frame("after_overrun");
    pulse_clr();
    check_flags("clr_after_overrun");

    // Reset in the middle of a MAC.
    rand_inputs();
    lrc = 1'b1;
    repeat (5) @(negedge clk);
    chk("mac_busy_before_reset", 32'(st0 != 2'd0), 32'd1);
    rst = 1'b1;
    lrc = 1'b0;
    #1;
    chk("reset_mid_mac_dacdat", 32'({dac0, dac1}), 32'd0);
    chk("reset_mid_mac_state", 32'({st0, st1}), 32'd0);
    m_clip_l = 1'b0;
    m_clip_r = 1'b0;
    m_ovr    = 1'b0;
    check_flags("reset_mid_mac");
    exp_q.delete();
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    rand_inputs();
    frame("post_reset_a");
    rand_inputs();
    frame("post_reset_b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
